// File: rtl/ecc_secded_pipe_decoder_if.sv
// Streaming bus for the SEC-DED decoder: input word handshake and corrected-output handshake.
// The check-bit width is derived from DATA_W here so both sides agree on the bus shape.
interface ecc_secded_pipe_decoder_if #(
    parameter int unsigned DATA_W = 128
);
    // Smallest r with 2^r >= DATA_W + r + 1
    function automatic int unsigned calc_chk_w(input int unsigned dw);
        int unsigned r;
        r = 0;
        for (int unsigned i = 1; i < 32; i++) begin
            if (r == 0 && (32'd1 << i) >= dw + i + 1) r = i;
        end
        return r;
    endfunction

    localparam int unsigned CHK_W = calc_chk_w(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CHK_W:0]    in_chk;
    logic              bypass;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sbe;
    logic              out_dbe;
    logic [CHK_W-1:0]  out_syndrome;

    modport master (
        output in_valid, in_data, in_chk, bypass, out_ready,
        input  in_ready, out_valid, out_data, out_sbe, out_dbe, out_syndrome
    );

    modport slave (
        input  in_valid, in_data, in_chk, bypass, out_ready,
        output in_ready, out_valid, out_data, out_sbe, out_dbe, out_syndrome
    );
endinterface

// File: rtl/ecc_secded_pipe_decoder.sv
// Two-stage pipelined SEC-DED Hamming decoder with valid/ready flow control and
// saturating single/double error counters counted on output handshakes.
module ecc_secded_pipe_decoder #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ecc_secded_pipe_decoder_if.slave bus,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        cnt_sbe,
    output logic [CNT_W-1:0]        cnt_dbe
);
    function automatic int unsigned calc_chk_w(input int unsigned dw);
        int unsigned r;
        r = 0;
        for (int unsigned i = 1; i < 32; i++) begin
            if (r == 0 && (32'd1 << i) >= dw + i + 1) r = i;
        end
        return r;
    endfunction

    localparam int unsigned CHK_W = calc_chk_w(DATA_W);
    localparam int unsigned N_POS = DATA_W + CHK_W;

    // Codeword position of data bit j: the (j+1)-th non-power-of-two position
    function automatic int unsigned data_pos(input int unsigned j);
        int unsigned n;
        int unsigned p;
        n = 0;
        p = 0;
        for (int unsigned q = 3; q <= N_POS; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (n == j) p = q;
                n++;
            end
        end
        return p;
    endfunction

    // Data bits whose position has bit k set
    function automatic logic [DATA_W-1:0] cover_mask(input int unsigned k);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int unsigned j = 0; j < DATA_W; j++) begin
            m[j] = ((data_pos(j) >> k) & 32'd1) != 0;
        end
        return m;
    endfunction

    logic [CHK_W-1:0]  syn_c;
    logic              par_c;
    logic              s2_load;
    logic              in_ready_c;

    logic              s1_v;
    logic [DATA_W-1:0] s1_data;
    logic [CHK_W-1:0]  s1_syn;
    logic              s1_par;
    logic              s1_byp;

    logic              s2_v;
    logic [DATA_W-1:0] s2_data;
    logic              s2_sbe;
    logic              s2_dbe;
    logic [CHK_W-1:0]  s2_syn;

    logic [DATA_W-1:0] flip_c;
    logic [DATA_W-1:0] dec_data_c;
    logic              dec_sbe_c;
    logic              dec_dbe_c;

    for (genvar k = 0; k < CHK_W; k++) begin : g_syn
        localparam logic [DATA_W-1:0] MASK = cover_mask(k);
        assign syn_c[k] = bus.in_chk[k] ^ (^(bus.in_data & MASK));
    end

    assign par_c = (^bus.in_data) ^ (^bus.in_chk);

    // in_ready looks through S2 to out_ready so a full pipe still streams at one word per cycle
    assign s2_load    = !s2_v || bus.out_ready;
    assign in_ready_c = !s1_v || s2_load;
    assign bus.in_ready = in_ready_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_syn  <= '0;
            s1_par  <= 1'b0;
            s1_byp  <= 1'b0;
        end else if (in_ready_c) begin
            s1_v <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data <= bus.in_data;
                s1_syn  <= syn_c;
                s1_par  <= par_c;
                s1_byp  <= bus.bypass;
            end
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_flip
        localparam int unsigned POS = data_pos(j);
        assign flip_c[j] = (s1_syn == CHK_W'(POS));
    end

    // Syndromes of zero or a power of two select no data bit, so flip_c is zero for them
    always_comb begin
        dec_data_c = s1_data;
        dec_sbe_c  = 1'b0;
        dec_dbe_c  = 1'b0;
        if (!s1_byp) begin
            if (s1_par) begin
                if (32'(s1_syn) > N_POS) begin
                    dec_dbe_c = 1'b1;
                end else begin
                    dec_sbe_c  = 1'b1;
                    dec_data_c = s1_data ^ flip_c;
                end
            end else if (s1_syn != '0) begin
                dec_dbe_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_data <= '0;
            s2_sbe  <= 1'b0;
            s2_dbe  <= 1'b0;
            s2_syn  <= '0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_data <= dec_data_c;
                s2_sbe  <= dec_sbe_c;
                s2_dbe  <= dec_dbe_c;
                s2_syn  <= s1_syn;
            end
        end
    end

    assign bus.out_valid    = s2_v;
    assign bus.out_data     = s2_data;
    assign bus.out_sbe      = s2_sbe;
    assign bus.out_dbe      = s2_dbe;
    assign bus.out_syndrome = s2_syn;

    // Clear takes priority over a same-cycle delivery
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            cnt_sbe <= '0;
            cnt_dbe <= '0;
        end else if (s2_v && bus.out_ready) begin
            if (s2_sbe && cnt_sbe != '1) cnt_sbe <= cnt_sbe + CNT_W'(1);
            if (s2_dbe && cnt_dbe != '1) cnt_dbe <= cnt_dbe + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ecc_secded_pipe_decoder.sv
// Bench for the pipelined SEC-DED decoder: directed vector table, hand-written flow-control
// and reset sequences, and a randomized stream checked against a position-XOR reference model.
module tb_ecc_secded_pipe_decoder;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned CHK_W  = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned NPOS   = DATA_W + CHK_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] cnt_sbe;
    logic [CNT_W-1:0] cnt_dbe;

    ecc_secded_pipe_decoder_if #(.DATA_W(DATA_W)) bus ();

    ecc_secded_pipe_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .cnt_clr (cnt_clr),
        .cnt_sbe (cnt_sbe),
        .cnt_dbe (cnt_dbe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sbe;
        logic              dbe;
        logic [CHK_W-1:0]  syn;
        logic              byp;
    } res_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CHK_W:0]    chk;
        logic              byp;
        logic [DATA_W-1:0] e_data;
        logic              e_sbe;
        logic              e_dbe;
        logic [CHK_W-1:0]  e_syn;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t exp_q[$];
    int   m_sbe = 0;
    int   m_dbe = 0;
    int   delivered = 0;
    int   accepted = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: syndrome is the XOR of the positions of all set codeword bits
    function automatic res_t model(input logic [DATA_W-1:0] d, input logic [CHK_W:0] c, input logic byp);
        res_t        r;
        int unsigned syn;
        int unsigned j;
        logic        b;
        logic        par;
        syn = 0;
        j = 0;
        for (int unsigned pos = 1; pos <= NPOS; pos++) begin
            if ((pos & (pos - 1)) == 0) b = c[$clog2(pos)];
            else begin
                b = d[j];
                j++;
            end
            if (b) syn ^= pos;
        end
        par = (^d) ^ (^c);
        r.data = d;
        r.sbe = 1'b0;
        r.dbe = 1'b0;
        r.syn = CHK_W'(syn);
        r.byp = byp;
        if (!byp) begin
            if (par) begin
                if (syn > NPOS) r.dbe = 1'b1;
                else begin
                    r.sbe = 1'b1;
                    // data index = position - 1 - (number of powers of two <= position)
                    if (syn != 0 && (syn & (syn - 1)) != 0)
                        r.data[syn - 2 - ($clog2(syn + 1) - 1)] = ~d[syn - 2 - ($clog2(syn + 1) - 1)];
                end
            end else if (syn != 0) begin
                r.dbe = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [CHK_W:0] encode(input logic [DATA_W-1:0] d);
        res_t             r;
        logic [CHK_W-1:0] s;
        r = model(d, '0, 1'b1);
        s = r.syn;
        return {(^d) ^ (^s), s};
    endfunction

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CHK_W:0] c,
                         input logic byp, input logic rdy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_chk    = c;
        bus.bypass    = byp;
        bus.out_ready = rdy;
    endtask

    // One cycle of streaming with scoreboard update; inputs set on negedge, handshakes judged #1 later
    task automatic tick(input logic v, input logic [DATA_W-1:0] d, input logic [CHK_W:0] c,
                        input logic byp, input logic rdy);
        res_t e;
        @(negedge clk);
        drive(v, d, c, byp, rdy);
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("stream_data", bus.out_data, e.data);
                check("stream_sbe", DATA_W'(bus.out_sbe), DATA_W'(e.sbe));
                check("stream_dbe", DATA_W'(bus.out_dbe), DATA_W'(e.dbe));
                if (!e.byp) check("stream_syn", DATA_W'(bus.out_syndrome), DATA_W'(e.syn));
                delivered++;
                if (e.sbe) m_sbe++;
                if (e.dbe) m_dbe++;
            end
        end
        if (v && bus.in_ready) begin
            exp_q.push_back(model(d, c, byp));
            accepted++;
        end
        @(posedge clk);
    endtask

    task automatic send_one(input vec_t v, output res_t got, output int lat);
        @(negedge clk);
        drive(1'b1, v.data, v.chk, v.byp, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = -1;
        got.data = '0; got.sbe = 1'b0; got.dbe = 1'b0; got.syn = '0; got.byp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) begin
                lat = i + 1;
                got.data = bus.out_data;
                got.sbe  = bus.out_sbe;
                got.dbe  = bus.out_dbe;
                got.syn  = bus.out_syndrome;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    task automatic rand_word(output logic [DATA_W-1:0] d, output logic [CHK_W:0] c, output logic byp);
        int unsigned mode;
        int unsigned b1;
        int unsigned b2;
        d = {$urandom, $urandom, $urandom, $urandom};
        c = encode(d);
        byp = 1'b0;
        mode = $urandom_range(0, 9);
        b1 = $urandom_range(0, NPOS);
        b2 = (b1 + 1 + $urandom_range(0, NPOS - 1)) % (NPOS + 1);
        if (mode >= 3 && mode != 8) begin
            if (b1 < DATA_W) d[b1] = ~d[b1]; else c[b1 - DATA_W] = ~c[b1 - DATA_W];
        end
        if (mode == 6 || mode == 7) begin
            if (b2 < DATA_W) d[b2] = ~d[b2]; else c[b2 - DATA_W] = ~c[b2 - DATA_W];
        end
        if (mode == 8) c = CHK_W'($urandom) | ((CHK_W + 1)'($urandom_range(0, 1)) << CHK_W);
        if (mode == 9) byp = 1'b1;
    endtask

    vec_t              tbl[9];
    res_t              got;
    int                lat;
    int                exp_sbe_cnt;
    int                exp_dbe_cnt;
    logic [DATA_W-1:0] wd[4];
    logic [CHK_W:0]    wc[4];
    logic [DATA_W-1:0] rd;
    logic [CHK_W:0]    rc;
    logic              rb;
    int                idx;
    int                stale;

    initial begin
        tbl[0] = '{data: 128'h0, chk: 9'h000, byp: 1'b0, e_data: 128'h0, e_sbe: 1'b0, e_dbe: 1'b0, e_syn: 8'h00};
        tbl[1] = '{data: 128'h1, chk: 9'h000, byp: 1'b0, e_data: 128'h0, e_sbe: 1'b1, e_dbe: 1'b0, e_syn: 8'h03};
        tbl[2] = '{data: 128'h0, chk: 9'h004, byp: 1'b0, e_data: 128'h0, e_sbe: 1'b1, e_dbe: 1'b0, e_syn: 8'h04};
        tbl[3] = '{data: 128'h0, chk: 9'h100, byp: 1'b0, e_data: 128'h0, e_sbe: 1'b1, e_dbe: 1'b0, e_syn: 8'h00};
        tbl[4] = '{data: 128'h3, chk: 9'h000, byp: 1'b0, e_data: 128'h3, e_sbe: 1'b0, e_dbe: 1'b1, e_syn: 8'h06};
        tbl[5] = '{data: 128'h4, chk: 9'h000, byp: 1'b0, e_data: 128'h0, e_sbe: 1'b1, e_dbe: 1'b0, e_syn: 8'h06};
        tbl[6] = '{data: {1'b1, 127'h0}, chk: 9'h000, byp: 1'b0, e_data: 128'h0, e_sbe: 1'b1, e_dbe: 1'b0, e_syn: 8'h88};
        tbl[7] = '{data: 128'h0, chk: 9'h1F0, byp: 1'b0, e_data: 128'h0, e_sbe: 1'b0, e_dbe: 1'b1, e_syn: 8'hF0};
        tbl[8] = '{data: 128'h1, chk: 9'h000, byp: 1'b1, e_data: 128'h1, e_sbe: 1'b0, e_dbe: 1'b0, e_syn: 8'h00};

        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", DATA_W'(bus.out_valid), 0);
        check("rst_in_ready", DATA_W'(bus.in_ready), 1);
        check("rst_out_data", bus.out_data, 0);
        check("rst_flags", DATA_W'({bus.out_sbe, bus.out_dbe}), 0);
        check("rst_syn", DATA_W'(bus.out_syndrome), 0);
        check("rst_cnt", DATA_W'({cnt_sbe, cnt_dbe}), 0);
        rst_n = 1'b1;

        // Directed vectors
        exp_sbe_cnt = 0;
        exp_dbe_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            send_one(tbl[i], got, lat);
            check($sformatf("vec%0d_latency", i), DATA_W'(lat), 2);
            check($sformatf("vec%0d_data", i), got.data, tbl[i].e_data);
            check($sformatf("vec%0d_sbe", i), DATA_W'(got.sbe), DATA_W'(tbl[i].e_sbe));
            check($sformatf("vec%0d_dbe", i), DATA_W'(got.dbe), DATA_W'(tbl[i].e_dbe));
            if (!tbl[i].byp) check($sformatf("vec%0d_syn", i), DATA_W'(got.syn), DATA_W'(tbl[i].e_syn));
            if (tbl[i].e_sbe) exp_sbe_cnt++;
            if (tbl[i].e_dbe) exp_dbe_cnt++;
        end
        @(negedge clk);
        check("vec_cnt_sbe", DATA_W'(cnt_sbe), DATA_W'(exp_sbe_cnt));
        check("vec_cnt_dbe", DATA_W'(cnt_dbe), DATA_W'(exp_dbe_cnt));

        // DBE counter saturation
        pulse_clr();
        drive(1'b1, 128'h3, '0, 1'b0, 1'b1);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("sat_cnt_dbe", DATA_W'(cnt_dbe), 128'hFFFF);
        check("sat_cnt_sbe", DATA_W'(cnt_sbe), 0);

        // Backpressure: four words offered while output is stalled for 5 cycles
        pulse_clr();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
            wc[i] = encode(wd[i]);
            wd[i][i * 7] = ~wd[i][i * 7];
        end
        accepted = 0;
        delivered = 0;
        idx = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            tick(1'b1, wd[idx], wc[idx], 1'b0, 1'b0);
            idx = accepted;
        end
        @(negedge clk);
        check("bp_accepted", DATA_W'(accepted), 2);
        check("bp_in_ready", DATA_W'(bus.in_ready), 0);
        check("bp_out_valid", DATA_W'(bus.out_valid), 1);
        for (int cyc = 0; cyc < 30 && !(accepted == 4 && exp_q.size() == 0); cyc++) begin
            if (accepted < 4) tick(1'b1, wd[accepted], wc[accepted], 1'b0, 1'b1);
            else tick(1'b0, '0, '0, 1'b0, 1'b1);
        end
        check("bp_delivered", DATA_W'(delivered), 4);
        @(negedge clk);
        check("bp_cnt_sbe", DATA_W'(cnt_sbe), 4);

        // Clear coinciding with an SBE delivery
        tick(1'b1, 128'h1, '0, 1'b0, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        cnt_clr = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("clr_hs_valid", DATA_W'(bus.out_valid), 1);
        check("clr_hs_sbe", DATA_W'(bus.out_sbe), 1);
        @(posedge clk);
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr_hs_cnt_sbe", DATA_W'(cnt_sbe), 0);
        exp_q.delete();

        // Reset with both stages full
        tick(1'b1, 128'h1, '0, 1'b0, 1'b1);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        tick(1'b1, 128'h3, '0, 1'b0, 1'b0);
        tick(1'b1, 128'h5, '0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("pre_rst_cnt_sbe", DATA_W'(cnt_sbe), 1);
        check("pre_rst_out_valid", DATA_W'(bus.out_valid), 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_out_valid", DATA_W'(bus.out_valid), 0);
        check("mid_rst_cnt", DATA_W'({cnt_sbe, cnt_dbe}), 0);
        check("mid_rst_in_ready", DATA_W'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        exp_q.delete();
        stale = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("mid_rst_stale", DATA_W'(stale), 0);
        send_one(tbl[8], got, lat);
        check("rst_byp_data", got.data, 128'h1);
        check("rst_byp_flags", DATA_W'({got.sbe, got.dbe}), 0);

        // Randomized stream against the reference model
        pulse_clr();
        exp_q.delete();
        m_sbe = 0;
        m_dbe = 0;
        delivered = 0;
        accepted = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rand_word(rd, rc, rb);
            tick(($urandom_range(0, 3) != 0), rd, rc, rb, ($urandom_range(0, 3) != 0));
        end
        for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) tick(1'b0, '0, '0, 1'b0, 1'b1);
        check("rand_drained", DATA_W'(exp_q.size()), 0);
        check("rand_count", DATA_W'(delivered), DATA_W'(accepted));
        @(negedge clk);
        check("rand_cnt_sbe", DATA_W'(cnt_sbe), DATA_W'(m_sbe));
        check("rand_cnt_dbe", DATA_W'(cnt_dbe), DATA_W'(m_dbe));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
